btc_status_tx: RTL and testbench

BTC_STATUS_TX -- requirements
Module: btc_status_tx

---
 rtl/btc_miner_pkg.sv | 21 ++
 rtl/btc_status_fifo.sv | 68 ++++++
 rtl/btc_status_tx.sv | 142 ++++++++++++++
 tb/tb_btc_status_tx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/btc_miner_pkg.sv
// Shared definitions for the status transmitter: FSM state encoding,
// pin-level status code constants and a small counter-load helper.
package btc_miner_pkg;

   // Transmitter FSM states; GAP is only reachable when the gap feature is built in.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_GAP  = 2'd2
   } tx_state_e;

   localparam logic [15:0] IDLE_CODE    = 16'h0000;
   localparam logic [15:0] STATUS_START = 16'hFEED;
   localparam logic [15:0] STATUS_DONE  = 16'hDEAD;

   // A phase lasting N cycles loads the down-counter with N-1 and ends when it reads 0.
   function automatic logic [15:0] cycles_to_load(input int unsigned cycles);
      return 16'(cycles - 32'd1);
   endfunction

endpackage

// File: rtl/btc_status_fifo.sv
// Synchronous status-code queue with registered occupancy count.
// Pointers wrap naturally because DEPTH is a power of two. Push on full and
// pop on empty are ignored; clear_i empties the queue and beats push/pop.
module btc_status_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clear_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             full_s;
   logic             empty_s;
   logic             do_push_s;
   logic             do_pop_s;

   assign full_s    = (count_q == CW'(DEPTH));
   assign empty_s   = (count_q == CW'(0));
   assign do_push_s = push_i && !full_s;
   assign do_pop_s  = pop_i && !empty_s;

   // Pointer and occupancy bookkeeping; reset and clear both empty the queue.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         wr_ptr_q <= AW'(0);
         rd_ptr_q <= AW'(0);
         count_q  <= CW'(0);
      end else begin
         if (do_push_s) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage array write port; contents need no reset since count gates reads.
   always_ff @(posedge clk_i) begin
      if (!rst_i && !clear_i && do_push_s) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign empty_o = empty_s;

endmodule

// File: rtl/btc_status_tx.sv
// Status-code transmitter: queues 16-bit codes and shows each one on the
// upper user pads for HOLD_CYCLES cycles. Optional macro BTC_STATUS_TX_GAP_EN
// inserts GAP_CYCLES of IDLE_CODE between back-to-back codes so repeated
// identical codes stay distinguishable; without it consecutive codes abut.
module btc_status_tx
   import btc_miner_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int GAP_CYCLES  = 4
) (
   input  logic                          wb_clk_i,
   input  logic                          wb_rst_i,
   input  logic                          clear_i,
   input  logic                          status_valid_i,
   input  logic [15:0]                   status_code_i,
   output logic                          status_ready_o,
   output logic [15:0]                   io_out_o,
   output logic [15:0]                   io_oeb_o,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

   localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] HOLD_LOAD = cycles_to_load(HOLD_CYCLES);
   localparam logic [15:0] GAP_LOAD  = cycles_to_load(GAP_CYCLES);

   tx_state_e     state_q, state_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [15:0]   io_q, io_d;
   logic          pop_s;
   logic          push_s;
   logic [15:0]   head_s;
   logic [CW-1:0] fifo_count_s;
   logic          fifo_empty_s;

`ifndef BTC_STATUS_TX_GAP_EN
   logic unused_gap_s;
   assign unused_gap_s = ^GAP_LOAD;
`endif

   assign status_ready_o = !wb_rst_i && (fifo_count_s < CW'(FIFO_DEPTH));
   assign push_s         = status_valid_i && status_ready_o;

   btc_status_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (16)
   ) u_fifo (
      .clk_i   (wb_clk_i),
      .rst_i   (wb_rst_i),
      .clear_i (clear_i),
      .push_i  (push_s),
      .data_i  (status_code_i),
      .pop_i   (pop_s),
      .data_o  (head_s),
      .count_o (fifo_count_s),
      .empty_o (fifo_empty_s)
   );

   // Next-state, hold/gap counter and pad value; clear_i overrides everything.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      io_d    = io_q;
      pop_s   = 1'b0;
      if (clear_i) begin
         state_d = ST_IDLE;
         cnt_d   = 16'd0;
         io_d    = IDLE_CODE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!fifo_empty_s) begin
                  pop_s   = 1'b1;
                  io_d    = head_s;
                  cnt_d   = HOLD_LOAD;
                  state_d = ST_HOLD;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_HOLD: begin
               if (cnt_q != 16'd0) begin
                  cnt_d = cnt_q - 16'd1;
               end else if (fifo_empty_s) begin
                  // Nothing waiting: park in IDLE with the last code still shown.
                  state_d = ST_IDLE;
               end else begin
`ifdef BTC_STATUS_TX_GAP_EN
                  state_d = ST_GAP;
                  io_d    = IDLE_CODE;
                  cnt_d   = GAP_LOAD;
`else
                  pop_s   = 1'b1;
                  io_d    = head_s;
                  cnt_d   = HOLD_LOAD;
                  state_d = ST_HOLD;
`endif
               end
            end
`ifdef BTC_STATUS_TX_GAP_EN
            ST_GAP: begin
               if (cnt_q != 16'd0) begin
                  cnt_d = cnt_q - 16'd1;
               end else if (!fifo_empty_s) begin
                  pop_s   = 1'b1;
                  io_d    = head_s;
                  cnt_d   = HOLD_LOAD;
                  state_d = ST_HOLD;
               end else begin
                  state_d = ST_IDLE;
               end
            end
`endif
            default: begin
               state_d = ST_IDLE;
               cnt_d   = 16'd0;
               io_d    = IDLE_CODE;
            end
         endcase
      end
   end

   // State, counter and pad registers with synchronous active-high reset.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= 16'd0;
         io_q    <= IDLE_CODE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         io_q    <= io_d;
      end
   end

   assign io_out_o     = io_q;
   assign io_oeb_o     = wb_rst_i ? 16'hFFFF : 16'h0000;
   assign busy_o       = (state_q != ST_IDLE) || !fifo_empty_s;
   assign fifo_count_o = fifo_count_s;

endmodule

// File: tb/tb_btc_status_tx.sv
// Self-checking bench for btc_status_tx. The reference model keeps a list of
// accepted codes with their acceptance edge and derives each code's display
// start edge arithmetically; pad value, queue occupancy, ready and busy are
// computed from those timelines every cycle.
module tb_btc_status_tx;
   import btc_miner_pkg::*;

   localparam int DEPTH = 4;
   localparam int HOLD  = 16;
   localparam int GAP   = 4;
`ifdef BTC_STATUS_TX_GAP_EN
   localparam int GAP_EFF = GAP;
`else
   localparam int GAP_EFF = 0;
`endif

   logic        wb_clk_i;
   logic        wb_rst_i;
   logic        clear_i;
   logic        status_valid_i;
   logic [15:0] status_code_i;
   logic        status_ready_o;
   logic [15:0] io_out_o;
   logic [15:0] io_oeb_o;
   logic        busy_o;
   logic [2:0]  fifo_count_o;

   btc_status_tx #(
      .FIFO_DEPTH  (DEPTH),
      .HOLD_CYCLES (HOLD),
      .GAP_CYCLES  (GAP)
   ) dut (
      .wb_clk_i       (wb_clk_i),
      .wb_rst_i       (wb_rst_i),
      .clear_i        (clear_i),
      .status_valid_i (status_valid_i),
      .status_code_i  (status_code_i),
      .status_ready_o (status_ready_o),
      .io_out_o       (io_out_o),
      .io_oeb_o       (io_oeb_o),
      .busy_o         (busy_o),
      .fifo_count_o   (fifo_count_o)
   );

   initial wb_clk_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;

   int          cyc;
   int          errors;
   int          checks;
   string       phase;
   logic        last_acc;
   int          acc_q[$];
   int          start_q[$];
   logic [15:0] code_q[$];

   // Codes waiting in the queue after edge t: accepted but not yet started.
   function automatic int m_count(input int t);
      int n = 0;
      foreach (acc_q[i]) if (acc_q[i] <= t && t < start_q[i]) n++;
      return n;
   endfunction

   function automatic logic m_busy(input int t);
      if (m_count(t) > 0) return 1'b1;
      foreach (start_q[i]) if (start_q[i] <= t && t < start_q[i] + HOLD) return 1'b1;
      return 1'b0;
   endfunction

   // Pad value after edge t: latest started code, blanked only while a queued
   // successor (present before expiry) waits out the gap.
   function automatic logic [15:0] m_io(input int t);
      int k = -1;
      foreach (start_q[i]) if (start_q[i] <= t) k = i;
      if (k < 0) return IDLE_CODE;
      if (t < start_q[k] + HOLD) return code_q[k];
      if (k + 1 < start_q.size() && acc_q[k+1] < start_q[k] + HOLD) return IDLE_CODE;
      return code_q[k];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s/%s: observed %h expected %h at cycle %0d", phase, tag, obs, exp, cyc);
      end
   endtask

   // One clock: drive inputs, update the model at the edge, check at negedge.
   task automatic step(input logic v, input logic [15:0] c, input logic clr, input logic rst);
      logic acc;
      int   s;
      int   e;
      status_valid_i = v;
      status_code_i  = c;
      clear_i        = clr;
      wb_rst_i       = rst;
      acc = v && !rst && !clr && (m_count(cyc) < DEPTH);
      @(posedge wb_clk_i);
      cyc++;
      if (rst || clr) begin
         acc_q.delete();
         start_q.delete();
         code_q.delete();
      end else if (acc) begin
         if (start_q.size() == 0) begin
            s = cyc + 1;
         end else begin
            e = start_q[$] + HOLD;
            s = (cyc < e) ? e + GAP_EFF : cyc + 1;
         end
         acc_q.push_back(cyc);
         start_q.push_back(s);
         code_q.push_back(c);
      end
      last_acc = acc;
      @(negedge wb_clk_i);
      check("io_out", 32'(io_out_o), 32'(m_io(cyc)));
      check("io_oeb", 32'(io_oeb_o), rst ? 32'hFFFF : 32'h0);
      check("ready", 32'(status_ready_o), 32'(!rst && (m_count(cyc) < DEPTH)));
      check("count", 32'(fifo_count_o), 32'(m_count(cyc)));
      check("busy", 32'(busy_o), 32'(m_busy(cyc)));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0, 1'b0);
   endtask

   logic [15:0] six_codes [6];
   int          n_acc;
   int          fall_at;
   int          pv;
   logic        rv;
   logic        rc;
   logic        rr;

   initial begin
      cyc = 0; errors = 0; checks = 0; last_acc = 1'b0;
      wb_rst_i = 1'b1; clear_i = 1'b0; status_valid_i = 1'b0; status_code_i = 16'h0000;

      // Reset held for five cycles, valid offered to show it is ignored.
      phase = "reset";
      for (int i = 0; i < 5; i++) step(1'b1, 16'h1234, 1'b0, 1'b1);
      check("rst_io_out", 32'(io_out_o), 32'h0);
      phase = "release";
      idle(1);
      check("rel_oeb", 32'(io_oeb_o), 32'h0);
      check("rel_ready", 32'(status_ready_o), 32'h1);

      // FEED then DEAD back-to-back.
      phase = "feed_dead";
      step(1'b1, STATUS_START, 1'b0, 1'b0);
      step(1'b1, STATUS_DONE, 1'b0, 1'b0);
      check("feed_shown", 32'(io_out_o), 32'hFEED);
      idle(60);
      check("dead_retained", 32'(io_out_o), 32'hDEAD);
      check("idle_not_busy", 32'(busy_o), 32'h0);

      // Valid held with six distinct codes until all are taken.
      phase = "fill";
      six_codes[0] = 16'h1111; six_codes[1] = 16'h2222; six_codes[2] = 16'h3333;
      six_codes[3] = 16'h4444; six_codes[4] = 16'h5555; six_codes[5] = 16'h6666;
      n_acc = 0; fall_at = -1;
      for (int i = 0; i < 200 && n_acc < 6; i++) begin
         step(1'b1, six_codes[n_acc], 1'b0, 1'b0);
         if (last_acc) n_acc++;
         if (fall_at < 0 && status_ready_o === 1'b0) fall_at = n_acc;
      end
      check("six_accepted", 32'(n_acc), 32'd6);
      check("accepted_before_full", 32'(fall_at), 32'd5);
      idle(140);

      // Identical consecutive codes.
      phase = "repeat";
      step(1'b1, 16'hAAAA, 1'b0, 1'b0);
      step(1'b1, 16'hAAAA, 1'b0, 1'b0);
      idle(50);

      // Clear mid-hold with two codes queued, plus a push in the clear cycle.
      phase = "clear";
      step(1'b1, 16'h0101, 1'b0, 1'b0);
      step(1'b1, 16'h0202, 1'b0, 1'b0);
      step(1'b1, 16'h0303, 1'b0, 1'b0);
      idle(4);
      check("pre_clear_count", 32'(fifo_count_o), 32'd2);
      step(1'b1, 16'h0404, 1'b1, 1'b0);
      check("clear_io", 32'(io_out_o), 32'h0);
      check("clear_count", 32'(fifo_count_o), 32'h0);
      check("clear_busy", 32'(busy_o), 32'h0);
      idle(6);
      check("clear_push_dropped", 32'(io_out_o), 32'h0);

      // Reset asserted inside the gap (inside hold when the gap is absent).
      phase = "rst_gap";
      step(1'b1, 16'h5A5A, 1'b0, 1'b0);
      step(1'b1, 16'hA5A5, 1'b0, 1'b0);
      idle(HOLD + 1);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      check("rst_gap_io", 32'(io_out_o), 32'h0);
      check("rst_gap_count", 32'(fifo_count_o), 32'h0);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      idle(40);
      check("no_stale", 32'(io_out_o), 32'h0);

      // Randomised traffic with occasional clear and reset.
      phase = "random";
      for (int b = 0; b < 8; b++) begin
         pv = int'($urandom_range(1, 9));
         for (int i = 0; i < 60; i++) begin
            rv = ($urandom_range(0, 9) < pv);
            rc = ($urandom_range(0, 79) == 0);
            rr = ($urandom_range(0, 149) == 0);
            step(rv, 16'($urandom), rc, rr);
         end
      end
      idle(160);
      check("drained_busy", 32'(busy_o), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
